alu_issue_wb: RTL and testbench

- Operand-fetch, issue and write-back stage that sits directly upstream and downstream of the 32-bit ALU (ADD/SUB/AND/OR/XOR/NOT/SLA/SRA/SRL, funct 0–8, result registered on posedge clk).
- Accepts one instruction word at a time through a valid/ready handshake.
- Reads operands from an internal 16x32 register file and drives the ALU's a/b/shamt/funct inputs.
- Captures the ALU result one cycle later and writes it back to the register file.

---
 rtl/alu_issue_wb.sv | 205 ++++++++++++++++++++
 tb/tb_alu_issue_wb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// Operand-fetch, issue and write-back stage wrapped around an external registered 32-bit ALU.
// Holds a 16x32 register file; one instruction in flight at a time (IDLE -> ISSUE -> CAPTURE).
module alu_issue_wb #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_res,
    output logic        done,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    function automatic logic [31:0] sign_ext10(input logic [9:0] v);
        return {{22{v[9]}}, v};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] rf_q [16];
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_shamt_q, alu_shamt_d;
    logic [3:0]  alu_funct_q, alu_funct_d;
    logic [3:0]  rd_q, rd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        rf_we_s;

    logic [3:0]  f_funct_s;
    logic        f_imm_sel_s;
    logic [4:0]  f_shamt_s;
    logic [3:0]  f_rd_s;
    logic [3:0]  f_rs_s;
    logic [3:0]  f_rt_s;
    logic [9:0]  f_imm_s;
    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic        accept_s;
    logic        legal_s;

    assign f_funct_s   = instr_data[31:28];
    assign f_imm_sel_s = instr_data[27];
    assign f_shamt_s   = instr_data[26:22];
    assign f_rd_s      = instr_data[21:18];
    assign f_rs_s      = instr_data[17:14];
    assign f_rt_s      = instr_data[13:10];
    assign f_imm_s     = instr_data[9:0];

    assign instr_ready = (state_q == S_IDLE);
    assign accept_s    = instr_valid && (state_q == S_IDLE);
    assign legal_s     = (f_funct_s <= 4'd8);

    // Register-file reads; R0 reads as zero when ZERO_REG is set.
    always_comb begin
        rs_val_s = rf_q[f_rs_s];
        rt_val_s = rf_q[f_rt_s];
        dbg_data = rf_q[dbg_addr];
        if (ZERO_REG && (f_rs_s == 4'd0)) begin
            rs_val_s = 32'd0;
        end else begin
            rs_val_s = rf_q[f_rs_s];
        end
        if (ZERO_REG && (f_rt_s == 4'd0)) begin
            rt_val_s = 32'd0;
        end else begin
            rt_val_s = rf_q[f_rt_s];
        end
        if (ZERO_REG && (dbg_addr == 4'd0)) begin
            dbg_data = 32'd0;
        end else begin
            dbg_data = rf_q[dbg_addr];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && legal_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand issue, error pulse and write-back.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_shamt_d = alu_shamt_q;
        alu_funct_d = alu_funct_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        rf_we_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s && legal_s) begin
                    alu_a_d     = rs_val_s;
                    alu_b_d     = f_imm_sel_s ? sign_ext10(f_imm_s) : rt_val_s;
                    alu_shamt_d = f_shamt_s;
                    alu_funct_d = f_funct_s;
                    rd_d        = f_rd_s;
                end else if (accept_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
            end
            S_ISSUE: begin
                done_d = 1'b0;
            end
            S_CAPTURE: begin
                wb_addr_d = rd_q;
                wb_data_d = alu_res;
                done_d    = 1'b1;
                rf_we_s   = !(ZERO_REG && (rd_q == 4'd0));
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_shamt_q <= 5'd0;
            alu_funct_q <= 4'd0;
            rd_q        <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wb_addr_q   <= 4'd0;
            wb_data_q   <= 32'd0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_shamt_q <= alu_shamt_d;
            alu_funct_q <= alu_funct_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    // Register file; a reset mid-operation clears it before any write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we_s) begin
            rf_q[rd_q] <= alu_res;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_shamt = alu_shamt_q;
    assign alu_funct = alu_funct_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a behavioural registered ALU attached.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    logic [31:0] alu_res;
    logic        done;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_wb #(.ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_res(alu_res), .done(done), .wb_addr(wb_addr), .wb_data(wb_data),
        .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Registered ALU stand-in.
    always_ff @(posedge clk) begin
        case (alu_funct)
            4'd0:    alu_res <= alu_a + alu_b;
            4'd1:    alu_res <= alu_a - alu_b;
            4'd2:    alu_res <= alu_a & alu_b;
            4'd3:    alu_res <= alu_a | alu_b;
            4'd4:    alu_res <= alu_a ^ alu_b;
            4'd5:    alu_res <= ~alu_a;
            4'd6:    alu_res <= alu_a << alu_shamt;
            4'd7:    alu_res <= $unsigned($signed(alu_a) >>> alu_shamt);
            4'd8:    alu_res <= alu_a >> alu_shamt;
            default: alu_res <= 32'd0;
        endcase
    end

    function automatic logic [31:0] enc(input logic [3:0] f, input logic is, input logic [4:0] sh,
                                        input logic [3:0] rd, input logic [3:0] rs,
                                        input logic [3:0] rt, input logic [9:0] imm);
        return {f, is, sh, rd, rs, rt, imm};
    endfunction

    // Presents one instruction and waits (bounded) for done; reports latency and ready-low cycles.
    task automatic exec(input logic [31:0] ins, input bit hold, output int lat, output int rlow,
                        output logic [3:0] wa, output logic [31:0] wd);
        instr_data  = ins;
        instr_valid = 1'b1;
        rlow = 0;
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            if (instr_ready === 1'b0) rlow++;
            @(posedge clk); #1;
            lat++;
        end
        instr_valid = 1'b0;
        wa = wb_addr;
        wd = wb_data;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; instr_valid = 1'b0; instr_data = 32'd0; dbg_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses done=%b err=%b exp=0/0", done, err); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_funct !== 4'd0 || alu_shamt !== 5'd0) begin
            failures++; $display("FAIL reset_alu a=%h b=%h f=%h sh=%h exp=0", alu_a, alu_b, alu_funct, alu_shamt); end
        checks++; if (wb_data !== 32'd0 || wb_addr !== 4'd0) begin failures++; $display("FAIL reset_wb addr=%h data=%h exp=0", wb_addr, wb_data); end
        for (int i = 0; i < 16; i++) begin
            read_reg(i[3:0], v);
            checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_rf r%0d got=%h exp=0", i, v); end
        end
    endtask

    task automatic test_add_imm();
        int lat, rlow; logic [3:0] wa; logic [31:0] wd, v;
        exec(enc(4'd0, 1'b1, 5'd0, 4'd1, 4'd0, 4'd0, 10'h005), 1'b0, lat, rlow, wa, wd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL add1_latency got=%0d exp=3", lat); end
        checks++; if (wa !== 4'd1 || wd !== 32'd5) begin failures++; $display("FAIL add1_wb addr=%h data=%h exp=1/5", wa, wd); end
        exec(enc(4'd0, 1'b1, 5'd0, 4'd2, 4'd1, 4'd0, 10'h3FF), 1'b0, lat, rlow, wa, wd);
        checks++; if (lat !== 3) begin failures++; $display("FAIL add2_latency got=%0d exp=3", lat); end
        checks++; if (wa !== 4'd2 || wd !== 32'd4) begin failures++; $display("FAIL add2_wb addr=%h data=%h exp=2/4", wa, wd); end
        checks++; if (alu_b !== 32'hFFFF_FFFF) begin failures++; $display("FAIL add2_signext alu_b=%h exp=ffffffff", alu_b); end
        read_reg(4'd2, v);
        checks++; if (v !== 32'd4) begin failures++; $display("FAIL add2_dbg r2=%h exp=4", v); end
    endtask

    task automatic test_back_to_back();
        int lat, rlow; logic [3:0] wa; logic [31:0] wd, v;
        exec(enc(4'd1, 1'b0, 5'd0, 4'd3, 4'd1, 4'd2, 10'h000), 1'b0, lat, rlow, wa, wd);
        checks++; if (wd !== 32'd1 || wa !== 4'd3) begin failures++; $display("FAIL sub_wb addr=%h data=%h exp=3/1", wa, wd); end
        checks++; if (rlow !== 2) begin failures++; $display("FAIL sub_ready_low got=%0d exp=2", rlow); end
        exec(enc(4'd6, 1'b0, 5'd4, 4'd4, 4'd3, 4'd0, 10'h000), 1'b0, lat, rlow, wa, wd);
        checks++; if (wd !== 32'h10 || wa !== 4'd4) begin failures++; $display("FAIL sla_wb addr=%h data=%h exp=4/10", wa, wd); end
        checks++; if (rlow !== 2 || lat !== 3) begin failures++; $display("FAIL sla_timing rlow=%0d lat=%0d exp=2/3", rlow, lat); end
        read_reg(4'd3, v);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL b2b_r3 got=%h exp=1", v); end
        read_reg(4'd4, v);
        checks++; if (v !== 32'h10) begin failures++; $display("FAIL b2b_r4 got=%h exp=10", v); end
    endtask

    task automatic test_illegal();
        logic [31:0] v;
        @(posedge clk); #1;
        instr_data  = enc(4'hC, 1'b1, 5'd0, 4'd5, 4'd1, 4'd0, 10'h001);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err); end
        checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL illegal_state done=%b ready=%b exp=0/1", done, instr_ready); end
        checks++; if (alu_funct !== 4'd6) begin failures++; $display("FAIL illegal_no_issue funct=%h exp=6", alu_funct); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (err !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1) begin
                failures++; $display("FAIL illegal_after err=%b done=%b ready=%b exp=0/0/1", err, done, instr_ready); end
        end
        read_reg(4'd5, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL illegal_r5 got=%h exp=0", v); end
        read_reg(4'd1, v);
        checks++; if (v !== 32'd5) begin failures++; $display("FAIL illegal_r1 got=%h exp=5", v); end
    endtask

    task automatic test_zero_reg();
        int lat, rlow; logic [3:0] wa; logic [31:0] wd, v;
        exec(enc(4'd0, 1'b1, 5'd0, 4'd0, 4'd0, 4'd0, 10'h007), 1'b0, lat, rlow, wa, wd);
        checks++; if (lat !== 3 || wa !== 4'd0 || wd !== 32'd7) begin
            failures++; $display("FAIL zero_wb lat=%0d addr=%h data=%h exp=3/0/7", lat, wa, wd); end
        read_reg(4'd0, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL zero_r0 got=%h exp=0", v); end
    endtask

    task automatic test_reset_capture();
        logic [31:0] v;
        instr_data  = enc(4'd0, 1'b1, 5'd0, 4'd5, 4'd0, 4'd0, 10'h009);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstcap_done got=%b exp=0", done); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rstcap_ready got=%b exp=1", instr_ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstcap_done_late got=%b exp=0", done); end
        read_reg(4'd5, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL rstcap_r5 got=%h exp=0", v); end
        read_reg(4'd1, v);
        checks++; if (v !== 32'd0) begin failures++; $display("FAIL rstcap_r1 got=%h exp=0", v); end
    endtask

    task automatic test_not_sra();
        int lat, rlow; logic [3:0] wa; logic [31:0] wd, v;
        exec(enc(4'd0, 1'b1, 5'd0, 4'd1, 4'd0, 4'd0, 10'h001), 1'b0, lat, rlow, wa, wd);
        exec(enc(4'd6, 1'b0, 5'd31, 4'd1, 4'd1, 4'd0, 10'h000), 1'b0, lat, rlow, wa, wd);
        checks++; if (wd !== 32'h8000_0000) begin failures++; $display("FAIL setup_r1 got=%h exp=80000000", wd); end
        exec(enc(4'd5, 1'b0, 5'd0, 4'd6, 4'd1, 4'd0, 10'h000), 1'b1, lat, rlow, wa, wd);
        checks++; if (wd !== 32'h7FFF_FFFF || wa !== 4'd6) begin failures++; $display("FAIL not_wb addr=%h data=%h exp=6/7fffffff", wa, wd); end
        checks++; if (lat !== 3 || rlow !== 2) begin failures++; $display("FAIL not_hold lat=%0d rlow=%0d exp=3/2", lat, rlow); end
        exec(enc(4'd7, 1'b0, 5'd31, 4'd7, 4'd1, 4'd0, 10'h000), 1'b1, lat, rlow, wa, wd);
        checks++; if (wd !== 32'hFFFF_FFFF || wa !== 4'd7) begin failures++; $display("FAIL sra_wb addr=%h data=%h exp=7/ffffffff", wa, wd); end
        checks++; if (lat !== 3 || rlow !== 2) begin failures++; $display("FAIL sra_hold lat=%0d rlow=%0d exp=3/2", lat, rlow); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin
                failures++; $display("FAIL hold_extra done=%b ready=%b exp=0/1", done, instr_ready); end
        end
        read_reg(4'd6, v);
        checks++; if (v !== 32'h7FFF_FFFF) begin failures++; $display("FAIL r6 got=%h exp=7fffffff", v); end
        read_reg(4'd7, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL r7 got=%h exp=ffffffff", v); end
        read_reg(4'd1, v);
        checks++; if (v !== 32'h8000_0000) begin failures++; $display("FAIL r1_kept got=%h exp=80000000", v); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_illegal();
        test_zero_reg();
        test_reset_capture();
        test_not_sra();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
